// File: rtl/ledr_pwm_fader.sv
// ledr_pwm_fader: per-LED PWM brightness fader placed after the LED PIO.
// Each LED ramps one level per fade step toward full-on (pattern bit 1) or
// off (pattern bit 0). With enable low the registered pattern is passed
// straight through to the LEDs.
// Optional build macro LEDR_PWM_FADER_GAMMA_EN selects a square-law
// brightness curve for the PWM compare. Undefined gives a linear compare.
module ledr_pwm_fader #(
  parameter int WIDTH        = 16,
  parameter int LEVEL_BITS   = 4,
  parameter int PRESCALE     = 1024,
  parameter int STEP_PERIODS = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pattern_in,
  input  logic             enable,
  output logic [WIDTH-1:0] led_out,
  output logic             busy
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int SC_W = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;

  localparam logic [LEVEL_BITS-1:0] MAXL     = LEVEL_BITS'((1 << LEVEL_BITS) - 1);
  localparam logic [LEVEL_BITS-1:0] PWM_LAST = LEVEL_BITS'((1 << LEVEL_BITS) - 2);
  localparam logic [PS_W-1:0]       PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [SC_W-1:0]       SC_LAST  = SC_W'(STEP_PERIODS - 1);

  logic [WIDTH-1:0]      pat_reg;
  logic [PS_W-1:0]       prescale_reg;
  logic [LEVEL_BITS-1:0] pwm_reg;
  logic [SC_W-1:0]       step_cnt_reg;

  logic [WIDTH-1:0] led_next;
  logic [WIDTH-1:0] differ;
  logic             tick;
  logic             period_end;
  logic             step;

  // One PWM tick every PRESCALE clocks; a period is MAXL ticks; a fade step
  // fires once every STEP_PERIODS periods.
  assign tick       = (prescale_reg == PS_LAST);
  assign period_end = tick && (pwm_reg == PWM_LAST);
  assign step       = period_end && (step_cnt_reg == SC_LAST);

  // Timebase counters: run in fade mode, parked at zero in bypass so that a
  // later enable starts from a clean phase.
  always_ff @(posedge clk) begin
    if (!reset_n || !enable) begin
      prescale_reg <= '0;
      pwm_reg      <= '0;
      step_cnt_reg <= '0;
    end else begin
      prescale_reg <= tick ? '0 : prescale_reg + PS_W'(1);
      if (tick) begin
        pwm_reg <= (pwm_reg == PWM_LAST) ? '0 : pwm_reg + LEVEL_BITS'(1);
      end
      if (period_end) begin
        step_cnt_reg <= (step_cnt_reg == SC_LAST) ? '0 : step_cnt_reg + SC_W'(1);
      end
    end
  end

  // Per-LED brightness level and PWM compare.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_led
      logic [LEVEL_BITS-1:0] level_reg;
      logic [LEVEL_BITS-1:0] target;
      logic [LEVEL_BITS-1:0] eff;

      assign target = pat_reg[gi] ? MAXL : '0;

      // Saturating one-level move toward the target on each step; bypass
      // pins the level to its target so re-enabling shows no transient.
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          level_reg <= '0;
        end else if (!enable) begin
          level_reg <= target;
        end else if (step) begin
          if (pat_reg[gi] && (level_reg != MAXL)) begin
            level_reg <= level_reg + LEVEL_BITS'(1);
          end else if (!pat_reg[gi] && (level_reg != '0)) begin
            level_reg <= level_reg - LEVEL_BITS'(1);
          end
        end
      end

`ifdef LEDR_PWM_FADER_GAMMA_EN
      // Square-law curve: level^2 / 2^LEVEL_BITS, with full level kept at
      // exactly MAXL so the top end stays constantly on.
      logic [2*LEVEL_BITS-1:0] square;
      assign square = {{LEVEL_BITS{1'b0}}, level_reg} * {{LEVEL_BITS{1'b0}}, level_reg};
      assign eff    = (level_reg == MAXL) ? MAXL : LEVEL_BITS'(square >> LEVEL_BITS);
`else
      assign eff = level_reg;
`endif

      assign led_next[gi] = (eff > pwm_reg);
      assign differ[gi]   = (level_reg != target);
    end
  endgenerate

  // Input capture plus registered LED drive and busy flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pat_reg <= '0;
      led_out <= '0;
      busy    <= 1'b0;
    end else begin
      pat_reg <= pattern_in;
      led_out <= enable ? led_next : pat_reg;
      busy    <= enable && (|differ);
    end
  end

endmodule

// File: tb/tb_ledr_pwm_fader.sv
// Directed testbench for ledr_pwm_fader.
// Instance dut_a: LEVEL_BITS=2, PRESCALE=2, STEP_PERIODS=1 (step every 6 clocks).
// Instance dut_b: LEVEL_BITS=4, PRESCALE=2, STEP_PERIODS=1 (step every 30 clocks).
// Expected duty counts depend on whether LEDR_PWM_FADER_GAMMA_EN is defined.
module tb_ledr_pwm_fader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [15:0] pattern_a, pattern_b;
  logic        enable_a, enable_b;
  logic [15:0] led_a, led_b;
  logic        busy_a, busy_b;

  int errors = 0;
  int checks = 0;
  int edge_no = 0;
  logic hist_a [0:511];
  logic hist_b [0:511];

`ifdef LEDR_PWM_FADER_GAMMA_EN
  localparam int A_L1 = 0;   // small instance, level 1 -> eff 0
  localparam int A_L2 = 2;   // level 2 -> eff 1
  localparam int A_E7 = 0;
  localparam int B_L1 = 0;   // wide instance, level 1 -> eff 0
  localparam int B_L8 = 8;   // level 8 -> eff 4 (4/15 duty)
`else
  localparam int A_L1 = 2;
  localparam int A_L2 = 4;
  localparam int A_E7 = 1;
  localparam int B_L1 = 2;
  localparam int B_L8 = 16;  // 8/15 duty
`endif

  ledr_pwm_fader #(.WIDTH(16), .LEVEL_BITS(2), .PRESCALE(2), .STEP_PERIODS(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .pattern_in(pattern_a),
    .enable(enable_a), .led_out(led_a), .busy(busy_a)
  );

  ledr_pwm_fader #(.WIDTH(16), .LEVEL_BITS(4), .PRESCALE(2), .STEP_PERIODS(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .pattern_in(pattern_b),
    .enable(enable_b), .led_out(led_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      $display("[%0t] check %s observed=0x%0h expected=0x%0h ok", $time, tag, obs, exp);
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample outputs 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    edge_no++;
    if (edge_no < 512) begin
      hist_a[edge_no] = led_a[0];
      hist_b[edge_no] = led_b[0];
    end
  endtask

  task automatic run_to(input int e);
    while (edge_no < e) tick();
  endtask

  function automatic int cnt_a(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (hist_a[i] === 1'b1) n++;
    return n;
  endfunction

  function automatic int cnt_b(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (hist_b[i] === 1'b1) n++;
    return n;
  endfunction

  // Park both instances in bypass with an all-zero pattern, then restart edge numbering.
  task automatic settle_bypass();
    enable_a  = 1'b0;
    pattern_a = 16'h0000;
    enable_b  = 1'b0;
    pattern_b = 16'h0000;
    repeat (3) tick();
    edge_no = 0;
  endtask

  initial begin
    // Reset held 3 cycles with fade enabled and all targets on.
    reset_n   = 1'b0;
    pattern_a = 16'hFFFF;
    enable_a  = 1'b1;
    pattern_b = 16'h0000;
    enable_b  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_led", {16'h0, led_a}, 32'h0);
      chk("rst_busy", {31'h0, busy_a}, 32'h0);
    end
    reset_n = 1'b1;
    tick();
    chk("rel_led", {16'h0, led_a}, 32'h0);
    chk("rel_busy", {31'h0, busy_a}, 32'h0);

    // Bypass: two-cycle registered pass-through.
    enable_a  = 1'b0;
    pattern_a = 16'h0000;
    repeat (3) tick();
    pattern_a = 16'hA5A5;
    tick();
    chk("byp_n1_led", {16'h0, led_a}, 32'h0);
    tick();
    chk("byp_n2_led", {16'h0, led_a}, 32'hA5A5);
    chk("byp_busy", {31'h0, busy_a}, 32'h0);
    tick();
    chk("byp_n3_led", {16'h0, led_a}, 32'hA5A5);

    // Fade-in of LED 0: steps land on edges 6, 12, 18.
    settle_bypass();
    enable_a  = 1'b1;
    pattern_a = 16'h0001;
    run_to(2);
    chk("fi_busy_e2", {31'h0, busy_a}, 32'h1);
    run_to(18);
    chk("fi_busy_e18", {31'h0, busy_a}, 32'h1);
    run_to(19);
    chk("fi_busy_e19", {31'h0, busy_a}, 32'h0);
    run_to(24);
    chk("fi_lvl0_duty", cnt_a(1, 6), 0);
    chk("fi_e7_led", {31'h0, hist_a[7]}, A_E7);
    chk("fi_lvl1_duty", cnt_a(7, 12), A_L1);
    chk("fi_lvl2_duty", cnt_a(13, 18), A_L2);
    chk("fi_lvl3_duty", cnt_a(19, 24), 6);
    chk("fi_other_leds", {16'h0, led_a & 16'hFFFE}, 32'h0);

    // Reversal at level 2: back down through level 1 to 0.
    settle_bypass();
    enable_a  = 1'b1;
    pattern_a = 16'h0001;
    run_to(12);
    pattern_a = 16'h0000;
    run_to(24);
    chk("rv_busy_e24", {31'h0, busy_a}, 32'h1);
    run_to(25);
    chk("rv_busy_e25", {31'h0, busy_a}, 32'h0);
    run_to(30);
    chk("rv_lvl1_duty", cnt_a(7, 12), A_L1);
    chk("rv_lvl2_duty", cnt_a(13, 18), A_L2);
    chk("rv_down1_duty", cnt_a(19, 24), A_L1);
    chk("rv_down0_duty", cnt_a(25, 30), 0);

    // Reset for one cycle at level 2, then the fade restarts from level 0.
    settle_bypass();
    enable_a  = 1'b1;
    pattern_a = 16'h0001;
    run_to(12);
    reset_n = 1'b0;
    run_to(13);
    chk("rmf_led", {16'h0, led_a}, 32'h0);
    chk("rmf_busy", {31'h0, busy_a}, 32'h0);
    reset_n = 1'b1;
    run_to(15);
    chk("rmf_busy_restart", {31'h0, busy_a}, 32'h1);
    run_to(22);
    chk("rmf_lvl0_duty", cnt_a(14, 19), 0);
    chk("rmf_e20_led", {31'h0, hist_a[20]}, A_E7);
    chk("rmf_e22_led", {16'h0, led_a}, 32'h0);
    // Drop to bypass mid-fade: LED follows the pattern on the next edge.
    enable_a = 1'b0;
    run_to(23);
    chk("dis_led", {16'h0, led_a}, 32'h0001);
    chk("dis_busy", {31'h0, busy_a}, 32'h0);

    // Wide instance: level k spans edges 30k+1 .. 30k+30.
    settle_bypass();
    enable_b  = 1'b1;
    pattern_b = 16'h0001;
    run_to(450);
    chk("b_busy_e450", {31'h0, busy_b}, 32'h1);
    run_to(451);
    chk("b_busy_e451", {31'h0, busy_b}, 32'h0);
    run_to(480);
    chk("b_lvl0_duty", cnt_b(1, 30), 0);
    chk("b_lvl1_duty", cnt_b(31, 60), B_L1);
    chk("b_lvl8_duty", cnt_b(241, 270), B_L8);
    chk("b_lvl15_duty", cnt_b(451, 480), 30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ledr_pwm_fader.md
Name: ledr_pwm_fader

Overview:
- Sits directly downstream of the 16-bit LED PIO. Consumes its `out_port` pattern and drives the board LEDs.
- Replaces hard on/off switching with per-LED PWM brightness that ramps smoothly toward each bit's target: fade-in on 1, fade-out on 0.
- Bypass mode passes the pattern straight through, registered.
- Purely local block; no bus interface.

Parameters:
- WIDTH, 16: number of LEDs (pattern width).
- LEVEL_BITS, 4: brightness resolution. MAXL = 2^LEVEL_BITS-1 (15 by default).
- PRESCALE, 1024: clk cycles per PWM tick (legal range ≥ 2).
- STEP_PERIODS, 4: complete PWM periods between successive fade steps (legal range ≥ 1).

Ports:
- clk, input, 1: system clock.
- reset_n, input, 1: synchronous, active-low reset.
- pattern_in, input, WIDTH: target pattern, driven from the LED PIO out_port.
- enable, input, 1: 1 = fade mode, 0 = bypass.
- led_out, output, WIDTH: physical LED drive, registered.
- busy, output, 1: registered; 1 while any LED level differs from its target.

Behaviour:
- Interface (already decided): one clock, `clk`. Reset `reset_n` is synchronous and active-low: sampled only on the rising edge of clk.
- Reset state: pat_q, levels, prescaler, pwm_cnt, step_cnt, led_out and busy all 0.
- Input register: pat_q <= pattern_in every cycle. The target for LED i is MAXL if pat_q[i] is 1, else 0.
- Prescaler: counts 0..PRESCALE-1, then wraps. `tick` is high for one cycle when the prescaler is at PRESCALE-1.
- PWM counter pwm_cnt: counts 0..MAXL-1, advancing on tick and wrapping to 0. A PWM period is therefore MAXL ticks = MAXL*PRESCALE cycles. `period_end` = tick && pwm_cnt==MAXL-1.
- Step counter step_cnt: counts 0..STEP_PERIODS-1, advancing on period_end. `step` is a one-cycle strobe when period_end && step_cnt==STEP_PERIODS-1.
- On step, for each LED i (saturating):
  - pat_q[i]=1 and level<MAXL: level+1.
  - pat_q[i]=0 and level>0: level-1.
  - Otherwise: hold.
- Direction reversal mid-fade: the new direction applies at the next step; no level jump.
- Fade mode output: led_out[i] <= (level_i > pwm_cnt).
  - Level 0 is always off; level MAXL is always on.
  - Level k is high for k of every MAXL ticks.
- Bypass (enable=0):
  - led_out <= pat_q.
  - Each level is forced to its target every cycle.
  - Prescaler, pwm_cnt and step_cnt are held at 0.
- Mode switching:
  - Enable 0→1: levels already equal their targets, so there is no visible transient. Counters start from 0.
  - Enable 1→0 mid-fade: led_out switches to pat_q on the next cycle.
- Latency:
  - Bypass: pattern_in to led_out is 2 cycles.
  - Fade mode: the first level change occurs at the next step strobe.
  - Full fade 0→MAXL: MAXL steps = MAXL*STEP_PERIODS*MAXL*PRESCALE cycles.
- busy <= enable && (any level_i != target_i). It is 0 in bypass.
- Reset asserted mid-fade: on the next clock edge every register returns to its reset value, including led_out=0.

Optional Feature:
- Macro: LEDR_PWM_FADER_GAMMA_EN.
- Defined: the PWM compare uses eff_i instead of level_i.
  - eff_i = MAXL when level_i==MAXL.
  - Otherwise eff_i = (level_i*level_i)>>LEVEL_BITS, computed at 2*LEVEL_BITS width.
  - This gives a perceptual (square-law) ramp. Endpoints stay exactly off and fully on.
- Undefined: linear compare (level_i > pwm_cnt) and no multiplier logic.
- Step timing and busy are identical in both builds.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with pattern_in=0xFFFF, enable=1 → led_out=0x0000, busy=0 during reset and on the first cycle after release.
- Bypass: enable=0, pattern_in 0x0000→0xA5A5 at cycle N → led_out=0xA5A5 from cycle N+2; busy stays 0.
- Fade-in (LEVEL_BITS=2, PRESCALE=2, STEP_PERIODS=1, enable=1): pattern_in 0x0000→0x0001 →
  - busy=1.
  - Level 1 gives led_out[0] high 2 of every 6 cycles.
  - Level 2 gives 4 of 6.
  - Level 3 is reached 18 cycles after the first step alignment; led_out[0] is then constantly 1 and busy=0.
- Reversal: same parameters, pattern_in returns to 0x0000 while level=2 → the next step gives level 1, then 0; led_out[0] ends constantly 0; no step ever exceeds ±1.
- Reset mid-fade: reset_n=0 for 1 cycle while level=2 → the next edge gives led_out=0, busy=0 and counters 0. After release, the fade restarts from level 0.
- Gamma build (default params, LEDR_PWM_FADER_GAMMA_EN defined) →
  - Level 8 gives duty 4/15.
  - Level 15 is constantly on; level 1 is constantly off.
  - The non-gamma build at level 8 gives duty 8/15.
